md5_range_scheduler: RTL and testbench
======================================

# md5_range_scheduler

Distributes the 32-bit candidate space of the brute-force MD5 search among N parallel hash cores. Each core receives a fixed-size chunk (base value plus implicit length 2^CHUNK_BITS), and chunks are granted in round-robin order. The scheduler tracks which cores are busy, captures the first reported match and stops issuing work. It replaces the single free-running candidate counter with a shared counter arbitrated between cores, and sits between the top-level control (buttons/UART) and the core array.

## Interface
- N_CORES, 4, number of requesting hash cores (2..16)
- CHUNK_BITS, 16, log2 of candidates per chunk (1..31)
- IDX_W, $clog2(N_CORES), width of core index
- CLK  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  level; begin search from candidate 0 (honoured in IDLE and DONE)
- stop  in  1  level; abort issuing, drain busy cores
- req  in  N_CORES  per-core request for a new chunk
- chunk_done  in  N_CORES  per-core one-cycle pulse: assigned chunk finished
- found  in  N_CORES  per-core one-cycle pulse: match in current chunk
- found_cand  in  32*N_CORES  candidate per core, valid with its found bit (core i at [32i+31:32i])
- grant  out  N_CORES  one-hot one-cycle grant pulse
- grant_base  out  32  first candidate of granted chunk, valid with grant
- busy  out  N_CORES  core holds an unfinished chunk
- running  out  1  state == RUN
- done  out  1  state == DONE
- match  out  1  a match has been captured
- match_value  out  32  captured candidate
- match_core  out  IDX_W  index of matching core
- chunks_issued  out  33-CHUNK_BITS  chunks granted since start

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset → IDLE. All outputs are 0 on reset; the RR pointer is 0.
- IDLE: no grants. start → RUN. On entry to RUN: next_base=0, chunks_issued=0, match/match_value/match_core cleared.
- RUN: eligible = req & ~busy. If eligible ≠ 0, grant exactly one core per cycle using round-robin from pointer p.
  - The first eligible index at or after p (mod N) wins.
  - After a grant to core i, p = (i+1) mod N.
  - Grant updates: busy[i] set, grant_base = next_base, next_base += 2^CHUNK_BITS (mod 2^32), chunks_issued += 1.
- Exhaustion: after the grant that makes chunks_issued == 2^(32-CHUNK_BITS), the next state is DRAIN. No further grants occur, and next_base is not reused.
- stop in RUN → DRAIN. No grant is issued in the cycle stop is sampled.
- found in RUN or DRAIN while match == 0:
  - Capture the lowest-index asserting core: match=1, match_value=found_cand of that core, match_core=index.
  - From RUN, go to DRAIN with no grant that cycle.
  - Once match == 1, later found pulses are ignored.
- found from a core with busy == 0 is ignored. found in IDLE or DONE is ignored.
- chunk_done[i] clears busy[i]. A pulse on a non-busy core is ignored. Multiple cores may complete in the same cycle.
- A grant and a chunk_done on the same core in the same cycle cannot occur, because busy masks the request. A grant to one core and chunk_done from another in the same cycle are both applied.
- DRAIN: no grants. When busy == 0 → DONE. If busy == 0 on entry, DONE follows on the next cycle.
- DONE: done=1. match fields hold their values. start → RUN (full restart as above). stop is ignored.
- reset in any state: immediate return to IDLE. All outputs and busy are cleared. Outstanding chunks are abandoned; cores must be reset by the same signal.
- chunks_issued saturates only by construction. Its maximum value is 2^(32-CHUNK_BITS).

## Timing
- All outputs are registered.
- Grant latency: req sampled at edge k → grant/grant_base valid for exactly the cycle after edge k.
- Throughput: one grant per cycle while cores are eligible. A core that is re-requesting is eligible again the cycle after it pulses chunk_done.
- running rises in the cycle after start is sampled in IDLE or DONE. The first grant is possible one cycle later (req is sampled in RUN).
- match rises one cycle after the found pulse.
- DRAIN → DONE transition happens one cycle after busy reaches 0. done rises on the following edge.
- start and stop sampled in the same cycle in IDLE: start wins (→ RUN). stop then drives DRAIN on the next cycle.

## Test plan
- Basic round-robin (N=4, CHUNK_BITS=28; all req=1, cores pulse chunk_done 3 cycles after grant):
  - Grants are cores 0,1,2,3,0,… with grant_base 0x00000000, 0x10000000, 0x20000000, …
  - After 16 grants: DRAIN, then done=1 and chunks_issued=16.
- Fairness: req=4'b1011 held with cores busy-free.
  - Grant order is 0,1,3,0,1,3…; core 2 is never granted.
- Match capture: found[2]=1 and found[1]=1 in the same cycle, with found_cand 0xDEADBEEF on core 1.
  - match=1, match_core=1, match_value=0xDEADBEEF.
  - No further grants; done=1 only after all busy bits clear.
- Stop mid-run: assert stop after 5 grants.
  - chunks_issued stays 5 and grant stays 0.
  - DONE after the outstanding chunk_done pulses; match=0.
- Edge pulses: chunk_done on an idle core and found from a non-busy core.
  - busy is unchanged and match stays 0.
- Reset mid-DRAIN, then restart:
  - All outputs are 0 and state is IDLE.
  - start then restarts with grant_base 0x00000000.
- Restart from DONE: start in DONE clears match and begins at base 0.

Source files
------------

// File: rtl/md5_range_scheduler.sv
// md5_range_scheduler: round-robin chunk dispatcher over the 32-bit candidate space with match capture
module md5_range_scheduler #(
  parameter int N_CORES    = 4,
  parameter int CHUNK_BITS = 16,
  parameter int IDX_W      = $clog2(N_CORES)
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic [N_CORES-1:0]      req,
  input  logic [N_CORES-1:0]      chunk_done,
  input  logic [N_CORES-1:0]      found,
  input  logic [32*N_CORES-1:0]   found_cand,
  output logic [N_CORES-1:0]      grant,
  output logic [31:0]             grant_base,
  output logic [N_CORES-1:0]      busy,
  output logic                    running,
  output logic                    done,
  output logic                    match,
  output logic [31:0]             match_value,
  output logic [IDX_W-1:0]        match_core,
  output logic [32-CHUNK_BITS:0]  chunks_issued
);
  localparam int CW = 33 - CHUNK_BITS;
  localparam logic [CW-1:0] LAST = CW'(1) << (32 - CHUNK_BITS);
  localparam logic [31:0] STEP = 32'd1 << CHUNK_BITS;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d, match_core_q, match_core_d, gidx, fidx, c;
  logic [31:0] base_q, base_d, grant_base_q, grant_base_d, match_value_q, match_value_d, fcand;
  logic [CW-1:0] chunks_q, chunks_d;
  logic [N_CORES-1:0] busy_q, busy_d, grant_q, grant_d, elig, fv;
  logic match_q, match_d, hit, fhit, capture;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    base_d = base_q;
    chunks_d = chunks_q;
    busy_d = busy_q & ~chunk_done;
    grant_d = '0;
    grant_base_d = grant_base_q;
    match_d = match_q;
    match_value_d = match_value_q;
    match_core_d = match_core_q;
    elig = req & ~busy_q;
    fv = found & busy_q;
    hit = 1'b0;
    gidx = '0;
    c = '0;
    fhit = 1'b0;
    fidx = '0;
    fcand = '0;
    // Scan downward so the closest eligible index at/after the pointer wins
    for (int k = N_CORES - 1; k >= 0; k--) begin
      c = IDX_W'((int'(ptr_q) + k) % N_CORES);
      if (elig[c]) begin
        hit = 1'b1;
        gidx = c;
      end
    end
    for (int k = N_CORES - 1; k >= 0; k--) begin
      if (fv[k]) begin
        fhit = 1'b1;
        fidx = IDX_W'(k);
        fcand = found_cand[32*k +: 32];
      end
    end
    capture = fhit && !match_q && (state_q == RUN || state_q == DRAIN);
    if (capture) begin
      match_d = 1'b1;
      match_value_d = fcand;
      match_core_d = fidx;
    end
    if ((state_q == IDLE || state_q == DONE) && start) begin
      state_d = RUN;
      base_d = '0;
      chunks_d = '0;
      match_d = 1'b0;
      match_value_d = '0;
      match_core_d = '0;
    end else if (state_q == RUN) begin
      if (capture || stop) state_d = DRAIN;
      else if (hit) begin
        grant_d[gidx] = 1'b1;
        busy_d[gidx] = 1'b1;
        grant_base_d = base_q;
        base_d = base_q + STEP;
        chunks_d = chunks_q + CW'(1);
        ptr_d = IDX_W'((int'(gidx) + 1) % N_CORES);
        state_d = (chunks_d == LAST) ? DRAIN : RUN;
      end
    end else if (state_q == DRAIN && busy_q == '0) state_d = DONE;
  end
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      base_q <= '0;
      chunks_q <= '0;
      busy_q <= '0;
      grant_q <= '0;
      grant_base_q <= '0;
      match_q <= 1'b0;
      match_value_q <= '0;
      match_core_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      base_q <= base_d;
      chunks_q <= chunks_d;
      busy_q <= busy_d;
      grant_q <= grant_d;
      grant_base_q <= grant_base_d;
      match_q <= match_d;
      match_value_q <= match_value_d;
      match_core_q <= match_core_d;
    end
  end
  assign grant = grant_q;
  assign grant_base = grant_base_q;
  assign busy = busy_q;
  assign running = state_q == RUN;
  assign done = state_q == DONE;
  assign match = match_q;
  assign match_value = match_value_q;
  assign match_core = match_core_q;
  assign chunks_issued = chunks_q;
endmodule

// File: tb/tb_md5_range_scheduler.sv
// tb_md5_range_scheduler: directed bench with a grant scoreboard and a simple core latency model
module tb_md5_range_scheduler;
  localparam int N = 4;
  localparam int CB = 28;
  logic CLK, reset, start, stop;
  logic [N-1:0] req, found, cd_model, cd_extra, chunk_done, grant, busy;
  logic [32*N-1:0] found_cand;
  logic [31:0] grant_base, match_value;
  logic running, done, match;
  logic [1:0] match_core;
  logic [32-CB:0] chunks_issued;
  typedef struct {int core; logic [31:0] base;} exp_t;
  exp_t exp_q[$];
  int tests, fails, gcount, lat;
  int tmr[N];
  assign chunk_done = cd_model | cd_extra;
  md5_range_scheduler #(.N_CORES(N), .CHUNK_BITS(CB)) dut (
    .CLK(CLK), .reset(reset), .start(start), .stop(stop), .req(req),
    .chunk_done(chunk_done), .found(found), .found_cand(found_cand),
    .grant(grant), .grant_base(grant_base), .busy(busy), .running(running),
    .done(done), .match(match), .match_value(match_value),
    .match_core(match_core), .chunks_issued(chunks_issued)
  );
  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end
  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic expect_grant(int core, int idx);
    exp_t e;
    e.core = core;
    e.base = 32'(idx) << CB;
    exp_q.push_back(e);
  endtask
  task automatic wait_grants(int n);
    for (int i = 0; i < 500 && gcount < n; i++) @(negedge CLK);
    check("grant_count", 64'(gcount), 64'(n));
  endtask
  task automatic wait_done();
    for (int i = 0; i < 500 && !done; i++) @(negedge CLK);
    check("reach_done", {63'd0, done}, 64'd1);
  endtask
  task automatic pulse_start();
    @(negedge CLK) start = 1;
    @(negedge CLK) start = 0;
  endtask
  task automatic do_reset();
    @(negedge CLK);
    reset = 1; start = 0; stop = 0; req = 0; found = 0; cd_extra = 0; found_cand = '0;
    repeat (2) @(negedge CLK);
    reset = 0;
    exp_q.delete();
    gcount = 0;
  endtask
  // Core model and scoreboard monitor, sampled just after each rising edge
  initial begin
    cd_model = '0;
    for (int i = 0; i < N; i++) tmr[i] = 0;
    forever begin
      @(posedge CLK);
      #1;
      cd_model = '0;
      if (reset) begin
        for (int i = 0; i < N; i++) tmr[i] = 0;
      end else begin
        for (int i = 0; i < N; i++) if (tmr[i] > 0) begin
          tmr[i]--;
          if (tmr[i] == 0) cd_model[i] = 1'b1;
        end
        if (grant != '0) begin
          gcount++;
          if (exp_q.size() == 0) check("unexpected_grant", 64'(grant), 64'd0);
          else begin
            exp_t e;
            e = exp_q.pop_front();
            check("grant", 64'(grant), 64'(1) << e.core);
            check("grant_base", 64'(grant_base), 64'(e.base));
          end
          for (int i = 0; i < N; i++) if (grant[i]) tmr[i] = lat;
        end
      end
    end
  end
  initial begin
    tests = 0; fails = 0; gcount = 0; lat = 3;
    reset = 1; start = 0; stop = 0; req = 0; found = 0; cd_extra = 0; found_cand = '0;
    do_reset();
    check("rst_outputs", {grant, busy, running, done, match, match_core}, 64'd0);
    check("rst_values", {grant_base, match_value}, 64'd0);
    check("rst_chunks", 64'(chunks_issued), 64'd0);
    // Basic round-robin through the whole 16-chunk space
    for (int i = 0; i < 16; i++) expect_grant(i % 4, i);
    req = 4'hF;
    pulse_start();
    check("running_after_start", {63'd0, running}, 64'd1);
    wait_grants(16);
    check("drain_after_exhaust", {62'd0, running, done}, 64'd0);
    wait_done();
    check("exhaust_chunks", 64'(chunks_issued), 64'd16);
    check("exhaust_busy", 64'(busy), 64'd0);
    check("exhaust_no_match", {63'd0, match}, 64'd0);
    check("sb_empty_basic", 64'(exp_q.size()), 64'd0);
    // Fairness: core 2 never requests
    do_reset();
    for (int i = 0; i < 6; i++) expect_grant((i % 3 == 2) ? 3 : i % 3, i);
    req = 4'b1011;
    pulse_start();
    wait_grants(6);
    stop = 1;
    @(negedge CLK) stop = 0;
    wait_done();
    check("fair_chunks", 64'(chunks_issued), 64'd6);
    check("sb_empty_fair", 64'(exp_q.size()), 64'd0);
    // Stop mid-run after five grants
    do_reset();
    for (int i = 0; i < 5; i++) expect_grant(i % 4, i);
    req = 4'hF;
    pulse_start();
    wait_grants(5);
    stop = 1;
    @(negedge CLK);
    check("stop_no_grant", 64'(grant), 64'd0);
    check("stop_running", {63'd0, running}, 64'd0);
    wait_done();
    stop = 0;
    check("stop_chunks", 64'(chunks_issued), 64'd5);
    check("stop_match", {63'd0, match}, 64'd0);
    check("stop_busy", 64'(busy), 64'd0);
    // Match capture: lowest index wins, later found ignored
    do_reset();
    lat = 40;
    for (int i = 0; i < 4; i++) expect_grant(i, i);
    req = 4'hF;
    pulse_start();
    wait_grants(4);
    found = 4'b0110;
    found_cand[32 +: 32] = 32'hDEADBEEF;
    found_cand[64 +: 32] = 32'h12345678;
    @(negedge CLK) found = 0;
    check("match_flag", {63'd0, match}, 64'd1);
    check("match_core", 64'(match_core), 64'd1);
    check("match_value", 64'(match_value), 64'hDEADBEEF);
    check("match_drain", {62'd0, running, done}, 64'd0);
    found = 4'b0001;
    found_cand[0 +: 32] = 32'h11111111;
    @(negedge CLK) found = 0;
    check("match_hold_value", 64'(match_value), 64'hDEADBEEF);
    check("match_hold_core", 64'(match_core), 64'd1);
    check("match_busy_held", 64'(busy), 64'hF);
    wait_done();
    check("match_done_busy", 64'(busy), 64'd0);
    check("match_done_value", 64'(match_value), 64'hDEADBEEF);
    check("sb_empty_match", 64'(exp_q.size()), 64'd0);
    // Pulses from idle cores are ignored
    do_reset();
    expect_grant(0, 0);
    req = 4'b0001;
    pulse_start();
    wait_grants(1);
    req = 0;
    cd_extra = 4'b0100;
    found = 4'b1000;
    found_cand[96 +: 32] = 32'hCAFEF00D;
    @(negedge CLK);
    cd_extra = 0;
    found = 0;
    @(negedge CLK);
    check("edge_busy", 64'(busy), 64'd1);
    check("edge_match", {63'd0, match}, 64'd0);
    check("edge_running", {63'd0, running}, 64'd1);
    // Reset while draining
    stop = 1;
    @(negedge CLK) stop = 0;
    check("drain_state", {62'd0, running, done}, 64'd0);
    check("drain_busy", 64'(busy), 64'd1);
    do_reset();
    check("rst2_outputs", {grant, busy, running, done, match, match_core}, 64'd0);
    check("rst2_chunks", 64'(chunks_issued), 64'd0);
    expect_grant(0, 0);
    req = 4'b0001;
    pulse_start();
    wait_grants(1);
    req = 0;
    found = 4'b0001;
    found_cand[0 +: 32] = 32'hA5A5A5A5;
    @(negedge CLK) found = 0;
    check("m2_value", 64'(match_value), 64'hA5A5A5A5);
    wait_done();
    check("m2_core", 64'(match_core), 64'd0);
    check("m2_hold", 64'(match_value), 64'hA5A5A5A5);
    // Restart from DONE clears the match and restarts at base 0
    expect_grant(0, 0);
    req = 4'b0001;
    pulse_start();
    check("restart_running", {63'd0, running}, 64'd1);
    check("restart_match", {63'd0, match}, 64'd0);
    check("restart_value", 64'(match_value), 64'd0);
    check("restart_chunks", 64'(chunks_issued), 64'd0);
    wait_grants(2);
    check("restart_chunks1", 64'(chunks_issued), 64'd1);
    req = 0;
    stop = 1;
    wait_done();
    stop = 0;
    check("sb_empty_end", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
